// File: rtl/local_network_interface.sv
// local_network_interface
//
// Per-node network interface sitting on the router's local injection and
// ejection channels.
//
// Injection path: the core pushes flits into a small FIFO. A three-state FSM
// (IDLE -> ARM -> REQ) presents the FIFO head on the router's local input.
// It raises inject_req only after the flit has been on inj_flit for one full
// cycle. A granted request pops the FIFO.
//
// Ejection path: every flit the router ejects with its valid bit set is
// pushed into a first-word-fall-through FIFO that the core drains. The router
// cannot be stalled, so a flit arriving into a full FIFO (with no same-cycle
// pop) is dropped and ej_overflow is latched.
//
// Handshakes:
//   core_tx_valid/core_tx_ready: a transfer happens on every rising edge
//     where both are 1. core_tx_ready depends only on registered occupancy.
//   core_rx_valid/core_rx_ready: a transfer happens on every rising edge
//     where both are 1. core_rx_flit is stable while core_rx_valid=1 and
//     core_rx_ready=0.
//   inject_req/inject_grant: a flit is consumed on every rising edge where
//     both are 1. inject_grant is ignored while inject_req=0.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   core_tx_flit/valid/ready   flits from the core into the injection FIFO
//   inj_flit, inject_req       to router inPortLocal / injectReq
//   inject_grant               from router injectGrant
//   ej_flit                    from router outPortLocal (registered there)
//   core_rx_flit/valid/ready   ejection FIFO head towards the core
//   ej_overflow                sticky: an ejected flit was dropped
//   inj_count, ej_count        16-bit wrapping flit counters
//   inj_state                  debug view of the injection FSM
//                              (0=IDLE, 1=ARM, 2=REQ)

`ifndef CHANNEL_SIZE
`define CHANNEL_SIZE 32
`endif
`ifndef VALID
`define VALID 31
`endif

module local_network_interface #(
    parameter int CHANNEL_SIZE = `CHANNEL_SIZE,
    parameter int VALID_BIT    = `VALID,
    parameter int INJ_DEPTH    = 4,
    parameter int EJ_DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CHANNEL_SIZE-1:0] core_tx_flit,
    input  logic                    core_tx_valid,
    output logic                    core_tx_ready,
    output logic [CHANNEL_SIZE-1:0] inj_flit,
    output logic                    inject_req,
    input  logic                    inject_grant,
    input  logic [CHANNEL_SIZE-1:0] ej_flit,
    output logic [CHANNEL_SIZE-1:0] core_rx_flit,
    output logic                    core_rx_valid,
    input  logic                    core_rx_ready,
    output logic                    ej_overflow,
    output logic [15:0]             inj_count,
    output logic [15:0]             ej_count,
    output logic [1:0]              inj_state
);

    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);

    localparam logic [IAW:0] INJ_FULL_OCC = (IAW+1)'(INJ_DEPTH);
    localparam logic [IAW:0] INJ_TWO      = (IAW+1)'(2);
    localparam logic [EAW:0] EJ_FULL_OCC  = (EAW+1)'(EJ_DEPTH);

    localparam logic [CHANNEL_SIZE-1:0] VALID_MASK =
        {{(CHANNEL_SIZE-1){1'b0}}, 1'b1} << VALID_BIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        REQ  = 2'd2
    } inj_state_t;

    inj_state_t state;

    // ------------------------------------------------------------------
    // Injection FIFO
    // ------------------------------------------------------------------
    logic [CHANNEL_SIZE-1:0] inj_mem [INJ_DEPTH];
    logic [IAW-1:0]          inj_wr_ptr;
    logic [IAW-1:0]          inj_rd_ptr;
    logic [IAW-1:0]          inj_rd_next;
    logic [IAW:0]            inj_occ;
    logic                    inj_full;
    logic                    inj_push;
    logic                    inj_pop;

    assign inj_full      = (inj_occ == INJ_FULL_OCC);
    assign core_tx_ready = ~inj_full;
    assign inj_push      = core_tx_valid & ~inj_full;
    // Only a grant seen while requesting consumes the head.
    assign inj_pop       = (state == REQ) & inject_grant;
    assign inj_rd_next   = inj_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (inj_push) begin
            inj_mem[inj_wr_ptr] <= core_tx_flit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_wr_ptr <= '0;
            inj_rd_ptr <= '0;
            inj_occ    <= '0;
        end else begin
            if (inj_push) inj_wr_ptr <= inj_wr_ptr + 1'b1;
            if (inj_pop)  inj_rd_ptr <= inj_rd_next;
            case ({inj_push, inj_pop})
                2'b10:   inj_occ <= inj_occ + 1'b1;
                2'b01:   inj_occ <= inj_occ - 1'b1;
                default: inj_occ <= inj_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Injection FSM. inj_flit is loaded when entering ARM so that the
    // router's input latch sees the new head one cycle before the request.
    // That gap also keeps a stale latched flit from being taken twice.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            inject_req <= 1'b0;
            inj_flit   <= '0;
            inj_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    inject_req <= 1'b0;
                    if (inj_occ != '0) begin
                        state    <= ARM;
                        inj_flit <= inj_mem[inj_rd_ptr] | VALID_MASK;
                    end else begin
                        inj_flit <= '0;
                    end
                end
                ARM: begin
                    state      <= REQ;
                    inject_req <= 1'b1;
                end
                REQ: begin
                    if (inject_grant) begin
                        inj_count  <= inj_count + 16'd1;
                        inject_req <= 1'b0;
                        // Decide from the pre-pop occupancy; a push landing
                        // on the same edge is picked up from IDLE next cycle.
                        if (inj_occ >= INJ_TWO) begin
                            state    <= ARM;
                            inj_flit <= inj_mem[inj_rd_next] | VALID_MASK;
                        end else begin
                            state    <= IDLE;
                            inj_flit <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    inject_req <= 1'b0;
                    inj_flit   <= '0;
                end
            endcase
        end
    end

    assign inj_state = state;

    // ------------------------------------------------------------------
    // Ejection FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [CHANNEL_SIZE-1:0] ej_mem [EJ_DEPTH];
    logic [EAW-1:0]          ej_wr_ptr;
    logic [EAW-1:0]          ej_rd_ptr;
    logic [EAW:0]            ej_occ;
    logic                    ej_full;
    logic                    ej_in_valid;
    logic                    ej_push;
    logic                    ej_pop;
    logic                    ej_drop;

    assign ej_full       = (ej_occ == EJ_FULL_OCC);
    assign core_rx_valid = (ej_occ != '0);
    assign ej_in_valid   = ej_flit[VALID_BIT];
    assign ej_pop        = core_rx_valid & core_rx_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign ej_push       = ej_in_valid & (~ej_full | ej_pop);
    assign ej_drop       = ej_in_valid & ej_full & ~ej_pop;
    // Gate the head so the output reads zero when empty (memory is not reset).
    assign core_rx_flit  = core_rx_valid ? ej_mem[ej_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (ej_push) begin
            ej_mem[ej_wr_ptr] <= ej_flit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ej_wr_ptr   <= '0;
            ej_rd_ptr   <= '0;
            ej_occ      <= '0;
            ej_count    <= '0;
            ej_overflow <= 1'b0;
        end else begin
            if (ej_push) begin
                ej_wr_ptr <= ej_wr_ptr + 1'b1;
                ej_count  <= ej_count + 16'd1;
            end
            if (ej_pop) ej_rd_ptr <= ej_rd_ptr + 1'b1;
            if (ej_drop) ej_overflow <= 1'b1;
            case ({ej_push, ej_pop})
                2'b10:   ej_occ <= ej_occ + 1'b1;
                2'b01:   ej_occ <= ej_occ - 1'b1;
                default: ej_occ <= ej_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_local_network_interface.sv
// Testbench for local_network_interface.

module tb_local_network_interface;

    localparam int W  = 32;
    localparam int VB = 31;
    localparam int ID = 4;
    localparam int ED = 4;
    localparam logic [W-1:0] VMASK = {{(W-1){1'b0}}, 1'b1} << VB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [W-1:0] core_tx_flit;
    logic         core_tx_valid;
    logic         core_tx_ready;
    logic [W-1:0] inj_flit;
    logic         inject_req;
    logic         inject_grant;
    logic [W-1:0] ej_flit;
    logic [W-1:0] core_rx_flit;
    logic         core_rx_valid;
    logic         core_rx_ready;
    logic         ej_overflow;
    logic [15:0]  inj_count;
    logic [15:0]  ej_count;
    logic [1:0]   inj_state;

    local_network_interface #(
        .CHANNEL_SIZE(W), .VALID_BIT(VB), .INJ_DEPTH(ID), .EJ_DEPTH(ED)
    ) dut (
        .clk(clk), .reset(reset),
        .core_tx_flit(core_tx_flit), .core_tx_valid(core_tx_valid),
        .core_tx_ready(core_tx_ready),
        .inj_flit(inj_flit), .inject_req(inject_req), .inject_grant(inject_grant),
        .ej_flit(ej_flit),
        .core_rx_flit(core_rx_flit), .core_rx_valid(core_rx_valid),
        .core_rx_ready(core_rx_ready),
        .ej_overflow(ej_overflow), .inj_count(inj_count), .ej_count(ej_count),
        .inj_state(inj_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Injection: queue of flits waiting to leave, plus the cycle index from
    // which the request may be high (a presented flit always sits one cycle
    // on the wire before it is requested).
    logic [W-1:0] exp_q[$];
    logic [W-1:0] ej_q[$];
    logic         m_busy;
    int           m_edge;
    int           m_req_from;
    logic         m_ovf;
    logic [15:0]  m_inj_cnt;
    logic [15:0]  m_ej_cnt;

    function automatic logic exp_req();
        return m_busy && (m_edge >= m_req_from);
    endfunction

    function automatic logic [W-1:0] exp_inj_flit();
        if (m_busy && exp_q.size() > 0) return exp_q[0] | VMASK;
        return '0;
    endfunction

    function automatic logic [W-1:0] exp_rx_flit();
        if (ej_q.size() > 0) return ej_q[0];
        return '0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        ej_q.delete();
        m_busy     = 1'b0;
        m_req_from = 0;
        m_ovf      = 1'b0;
        m_inj_cnt  = '0;
        m_ej_cnt   = '0;
    endtask

    // Apply what happens at the coming rising edge, from the current inputs.
    task automatic model_edge();
        int   n_i;
        int   n_e;
        logic pop_i;
        logic pop_e;
        n_i   = exp_q.size();
        pop_i = exp_req() && (inject_grant === 1'b1);
        if (pop_i) begin
            void'(exp_q.pop_front());
            m_inj_cnt = m_inj_cnt + 16'd1;
        end
        if (core_tx_valid && n_i < ID) exp_q.push_back(core_tx_flit);
        m_edge++;
        if (pop_i) begin
            if (n_i >= 2) m_req_from = m_edge + 1;
            else m_busy = 1'b0;
        end else if (!m_busy && n_i > 0) begin
            m_busy     = 1'b1;
            m_req_from = m_edge + 1;
        end
        n_e   = ej_q.size();
        pop_e = (n_e > 0) && core_rx_ready;
        if (pop_e) void'(ej_q.pop_front());
        if (ej_flit[VB]) begin
            if (n_e < ED || pop_e) begin
                ej_q.push_back(ej_flit);
                m_ej_cnt = m_ej_cnt + 16'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        if (reset) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_tx_valid = 1'b0;
        core_tx_flit  = '0;
        inject_grant  = 1'b0;
        ej_flit       = '0;
        core_rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (inject_req !== 1'b0) begin n_err++; $display("FAIL reset_inject_req got %0b exp 0", inject_req); end
        n_cmp++; if (inj_flit !== '0) begin n_err++; $display("FAIL reset_inj_flit got %h exp 0", inj_flit); end
        n_cmp++; if (core_rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid got %0b exp 0", core_rx_valid); end
        n_cmp++; if (core_rx_flit !== '0) begin n_err++; $display("FAIL reset_rx_flit got %h exp 0", core_rx_flit); end
        n_cmp++; if (ej_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0b exp 0", ej_overflow); end
        n_cmp++; if (inj_count !== 16'd0) begin n_err++; $display("FAIL reset_inj_count got %0d exp 0", inj_count); end
        n_cmp++; if (ej_count !== 16'd0) begin n_err++; $display("FAIL reset_ej_count got %0d exp 0", ej_count); end
        n_cmp++; if (core_tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready got %0b exp 1", core_tx_ready); end
        n_cmp++; if (inj_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", inj_state); end
    endtask

    task automatic test_single_inject();
        int req_cycles = 0;
        int first = -1;
        inject_grant  = 1'b1;
        core_tx_valid = 1'b1;
        core_tx_flit  = $urandom() & ~VMASK;   // valid bit must be forced by the DUT
        tick();
        core_tx_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_cmp++; if (inject_req !== exp_req()) begin n_err++; $display("FAIL single_req c=%0d got %0b exp %0b", c, inject_req, exp_req()); end
            n_cmp++; if (inj_flit !== exp_inj_flit()) begin n_err++; $display("FAIL single_flit c=%0d got %h exp %h", c, inj_flit, exp_inj_flit()); end
            if (inject_req === 1'b1) begin
                req_cycles++;
                if (first < 0) first = c;
            end
            tick();
        end
        inject_grant = 1'b0;
        n_cmp++; if (req_cycles != 1) begin n_err++; $display("FAIL single_req_cycles got %0d exp 1", req_cycles); end
        n_cmp++; if (first != 2) begin n_err++; $display("FAIL single_req_latency got %0d exp 2", first); end
        n_cmp++; if (inj_count !== 16'd1) begin n_err++; $display("FAIL single_inj_count got %0d exp 1", inj_count); end
    endtask

    task automatic test_burst();
        int n_inj = 0;
        int last = -1;
        logic [15:0] base;
        base = m_inj_cnt;
        inject_grant = 1'b0;
        for (int i = 0; i < ID; i++) begin
            n_cmp++; if (core_tx_ready !== (exp_q.size() < ID)) begin n_err++; $display("FAIL burst_tx_ready i=%0d got %0b", i, core_tx_ready); end
            core_tx_valid = 1'b1;
            core_tx_flit  = $urandom();
            tick();
        end
        n_cmp++; if (core_tx_ready !== 1'b0) begin n_err++; $display("FAIL burst_full_ready got %0b exp 0", core_tx_ready); end
        core_tx_flit = $urandom();             // offered while full: must be refused
        tick();
        core_tx_valid = 1'b0;
        inject_grant  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (inject_req !== exp_req()) begin n_err++; $display("FAIL burst_req c=%0d got %0b exp %0b", c, inject_req, exp_req()); end
            n_cmp++; if (inj_flit !== exp_inj_flit()) begin n_err++; $display("FAIL burst_flit c=%0d got %h exp %h", c, inj_flit, exp_inj_flit()); end
            if (inject_req === 1'b1) begin
                n_inj++;
                last = c;
            end
            tick();
        end
        inject_grant = 1'b0;
        n_cmp++; if (n_inj != ID) begin n_err++; $display("FAIL burst_injections got %0d exp %0d", n_inj, ID); end
        n_cmp++; if (last != 2 * ID - 2) begin n_err++; $display("FAIL burst_last_cycle got %0d exp %0d", last, 2 * ID - 2); end
        n_cmp++; if (inj_count !== base + 16'(ID)) begin n_err++; $display("FAIL burst_inj_count got %0d exp %0d", inj_count, base + 16'(ID)); end
    endtask

    task automatic test_grant_hold();
        logic [W-1:0] fa;
        logic [W-1:0] fb;
        logic [15:0]  cnt0;
        int           waited = 0;
        fa = $urandom();
        fb = $urandom();
        inject_grant  = 1'b0;
        core_tx_valid = 1'b1;
        core_tx_flit  = fa;
        tick();
        core_tx_valid = 1'b0;
        while (inject_req !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_cmp++; if (inject_req !== 1'b1) begin n_err++; $display("FAIL hold_wait_req timeout got %0b exp 1", inject_req); end
        cnt0 = m_inj_cnt;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (inj_flit !== (fa | VMASK)) begin n_err++; $display("FAIL hold_flit c=%0d got %h exp %h", c, inj_flit, fa | VMASK); end
            n_cmp++; if (inj_count !== cnt0) begin n_err++; $display("FAIL hold_count c=%0d got %0d exp %0d", c, inj_count, cnt0); end
            core_tx_valid = (c == 2);
            core_tx_flit  = fb;
            tick();
        end
        core_tx_valid = 1'b0;
        inject_grant  = 1'b1;
        tick();                                 // grant in REQ: takes fa
        n_cmp++; if (inject_req !== 1'b0) begin n_err++; $display("FAIL hold_arm_req got %0b exp 0", inject_req); end
        tick();                                 // grant pulse during ARM: ignored
        inject_grant = 1'b0;
        n_cmp++; if (inj_count !== cnt0 + 16'd1) begin n_err++; $display("FAIL hold_arm_ignored got %0d exp %0d", inj_count, cnt0 + 16'd1); end
        n_cmp++; if (inject_req !== 1'b1) begin n_err++; $display("FAIL hold_req_b got %0b exp 1", inject_req); end
        n_cmp++; if (inj_flit !== (fb | VMASK)) begin n_err++; $display("FAIL hold_flit_b got %h exp %h", inj_flit, fb | VMASK); end
        inject_grant = 1'b1;
        tick();
        inject_grant = 1'b0;
        n_cmp++; if (inj_count !== cnt0 + 16'd2) begin n_err++; $display("FAIL hold_count_b got %0d exp %0d", inj_count, cnt0 + 16'd2); end
        tick();
    endtask

    task automatic test_ej_overflow();
        logic [W-1:0] sent[5];
        logic [15:0]  base;
        base = m_ej_cnt;
        core_rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sent[i] = $urandom() | VMASK;
            ej_flit = sent[i];
            tick();
        end
        ej_flit = $urandom() & ~VMASK;          // not valid: ignored
        tick();
        ej_flit = '0;
        n_cmp++; if (ej_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b exp 1", ej_overflow); end
        n_cmp++; if (ej_count !== base + 16'd4) begin n_err++; $display("FAIL ovf_ej_count got %0d exp %0d", ej_count, base + 16'd4); end
        core_rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (core_rx_valid !== 1'b1) begin n_err++; $display("FAIL ovf_drain_valid i=%0d got %0b exp 1", i, core_rx_valid); end
            n_cmp++; if (core_rx_flit !== sent[i]) begin n_err++; $display("FAIL ovf_drain_flit i=%0d got %h exp %h", i, core_rx_flit, sent[i]); end
            tick();
        end
        core_rx_ready = 1'b0;
        n_cmp++; if (core_rx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty_valid got %0b exp 0", core_rx_valid); end
        n_cmp++; if (core_rx_flit !== '0) begin n_err++; $display("FAIL ovf_empty_flit got %h exp 0", core_rx_flit); end
    endtask

    task automatic test_ej_full_pop();
        logic [W-1:0] sent[5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sent[i]       = $urandom() | VMASK;
            ej_flit       = sent[i];
            core_rx_ready = (i == 4);           // pop and push on the full edge
            tick();
        end
        ej_flit       = '0;
        core_rx_ready = 1'b0;
        n_cmp++; if (ej_overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow got %0b exp 0", ej_overflow); end
        n_cmp++; if (ej_count !== 16'd5) begin n_err++; $display("FAIL fullpop_ej_count got %0d exp 5", ej_count); end
        core_rx_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            n_cmp++; if (core_rx_flit !== sent[i] || core_rx_valid !== 1'b1) begin n_err++; $display("FAIL fullpop_drain i=%0d got %h/%0b exp %h/1", i, core_rx_flit, core_rx_valid, sent[i]); end
            tick();
        end
        core_rx_ready = 1'b0;
        n_cmp++; if (core_rx_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_occupancy got %0b exp 0 after 4 pops", core_rx_valid); end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        inject_grant  = 1'b0;
        core_rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core_tx_valid = 1'b1;
            core_tx_flit  = $urandom();
            ej_flit       = (i < 2) ? ($urandom() | VMASK) : '0;
            tick();
        end
        core_tx_valid = 1'b0;
        ej_flit       = '0;
        while (inject_req !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_cmp++; if (inject_req !== 1'b1) begin n_err++; $display("FAIL midrst_wait_req timeout got %0b exp 1", inject_req); end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (inject_req !== 1'b0 || inj_flit !== '0) begin n_err++; $display("FAIL midrst_inj got req=%0b flit=%h exp 0/0", inject_req, inj_flit); end
        n_cmp++; if (core_rx_valid !== 1'b0 || core_rx_flit !== '0) begin n_err++; $display("FAIL midrst_rx got %0b/%h exp 0/0", core_rx_valid, core_rx_flit); end
        n_cmp++; if (inj_count !== 16'd0 || ej_count !== 16'd0) begin n_err++; $display("FAIL midrst_counts got %0d/%0d exp 0/0", inj_count, ej_count); end
        n_cmp++; if (core_tx_ready !== 1'b1 || ej_overflow !== 1'b0) begin n_err++; $display("FAIL midrst_ready_ovf got %0b/%0b exp 1/0", core_tx_ready, ej_overflow); end
        tick();
        #3;
        reset        = 1'b0;
        inject_grant = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++; if (inject_req !== 1'b0) begin n_err++; $display("FAIL midrst_no_inject c=%0d got %0b exp 0", c, inject_req); end
        end
        inject_grant = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            core_tx_valid = 1'($urandom_range(0, 1));
            core_tx_flit  = $urandom();
            inject_grant  = 1'($urandom_range(0, 1));
            ej_flit       = ($urandom_range(0, 9) < 6) ? ($urandom() | VMASK) : ($urandom() & ~VMASK);
            core_rx_ready = 1'($urandom_range(0, 1));
            n_cmp++; if (inject_req !== exp_req()) begin n_err++; $display("FAIL rnd_req c=%0d got %0b exp %0b", c, inject_req, exp_req()); end
            n_cmp++; if (inj_flit !== exp_inj_flit()) begin n_err++; $display("FAIL rnd_inj_flit c=%0d got %h exp %h", c, inj_flit, exp_inj_flit()); end
            n_cmp++; if (core_tx_ready !== (exp_q.size() < ID)) begin n_err++; $display("FAIL rnd_tx_ready c=%0d got %0b exp %0b", c, core_tx_ready, exp_q.size() < ID); end
            n_cmp++; if (core_rx_valid !== (ej_q.size() > 0)) begin n_err++; $display("FAIL rnd_rx_valid c=%0d got %0b exp %0b", c, core_rx_valid, ej_q.size() > 0); end
            n_cmp++; if (core_rx_flit !== exp_rx_flit()) begin n_err++; $display("FAIL rnd_rx_flit c=%0d got %h exp %h", c, core_rx_flit, exp_rx_flit()); end
            n_cmp++; if (ej_overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow c=%0d got %0b exp %0b", c, ej_overflow, m_ovf); end
            n_cmp++; if (inj_count !== m_inj_cnt) begin n_err++; $display("FAIL rnd_inj_count c=%0d got %0d exp %0d", c, inj_count, m_inj_cnt); end
            n_cmp++; if (ej_count !== m_ej_cnt) begin n_err++; $display("FAIL rnd_ej_count c=%0d got %0d exp %0d", c, ej_count, m_ej_cnt); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        core_rx_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            ej_flit = $urandom() | VMASK;
            tick();
        end
        n_cmp++; if (ej_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ej_max got %h exp ffff", ej_count); end
        ej_flit = $urandom() | VMASK;
        tick();
        ej_flit = '0;
        n_cmp++; if (ej_count !== 16'h0000) begin n_err++; $display("FAIL wrap_ej_zero got %h exp 0000", ej_count); end
        n_cmp++; if (ej_overflow !== 1'b0) begin n_err++; $display("FAIL wrap_overflow got %0b exp 0", ej_overflow); end
        n_cmp++; if (core_rx_flit !== exp_rx_flit()) begin n_err++; $display("FAIL wrap_rx_flit got %h exp %h", core_rx_flit, exp_rx_flit()); end
        core_rx_ready = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        m_edge = 0;
        reset  = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_inject();
        test_burst();
        test_grant_hold();
        test_ej_overflow();
        test_ej_full_pop();
        test_reset_mid();
        test_random();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/local_network_interface.md
# local_network_interface

Per-node network interface at the far end of the router's local injection and ejection channels. It buffers flits from the core and presents them on the router's local input with an inject request/grant handshake. It also captures flits ejected on the router's local output and hands them to the core with a valid/ready handshake. It sits between the processing core and the router's `inPortLocal`/`injectReq`/`injectGrant`/`outPortLocal` ports, one instance per node.

## Interface
- `CHANNEL_SIZE`, default `` `CHANNEL_SIZE `` from globalVariable.v: flit width.
- `VALID_BIT`, default `` `VALID `` from globalVariable.v: index of the flit valid bit.
- `INJ_DEPTH`, default 4: injection FIFO entries; power of 2, ≥2.
- `EJ_DEPTH`, default 4: ejection FIFO entries; power of 2, ≥2.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `core_tx_flit` in CHANNEL_SIZE: flit from the core.
- `core_tx_valid` in 1: `core_tx_flit` is offered.
- `core_tx_ready` out 1: injection FIFO not full.
- `inj_flit` out CHANNEL_SIZE: drives the router's `inPortLocal`.
- `inject_req` out 1: drives the router's `injectReq`.
- `inject_grant` in 1: from the router's `injectGrant`.
- `ej_flit` in CHANNEL_SIZE: from the router's `outPortLocal`, already registered.
- `core_rx_flit` out CHANNEL_SIZE: head of the ejection FIFO.
- `core_rx_valid` out 1: ejection FIFO not empty.
- `core_rx_ready` in 1: core accepts `core_rx_flit`.
- `ej_overflow` out 1: sticky flag, an ejected flit was dropped.
- `inj_count` out 16: flits injected, wraps modulo 2^16.
- `ej_count` out 16: flits accepted into the ejection FIFO, wraps modulo 2^16.

## Operation
**Injection FIFO**
- Push when `core_tx_valid & core_tx_ready`.
- `core_tx_ready = ~inj_full`, combinational from the registered occupancy.
- Pop on a granted injection only.
- Pointers are log2(INJ_DEPTH) bits and wrap; the count is log2(INJ_DEPTH)+1 bits.

**Injection FSM**, registered state:
- IDLE: `inject_req=0`, `inj_flit=0`. Go to ARM when the FIFO is non-empty.
- ARM: `inj_flit` = FIFO head with bit VALID_BIT forced to 1; `inject_req=0`. Always go to REQ next cycle.
  - Purpose: the router's input latch must capture the head flit before a request is raised.
- REQ: `inj_flit` = head with valid forced to 1; `inject_req=1`.
  - On `inject_grant=1`: pop the FIFO and increment `inj_count`.
  - Next state after a grant is ARM if at least 2 entries were present, else IDLE.
  - Without a grant, stay in REQ with the flit held stable.
- `inject_grant` is ignored in IDLE and ARM.
- Throughput: at most one flit every 2 cycles. The mandatory ARM cycle keeps a stale latched flit from being injected twice.

**Ejection**
- On each edge where `ej_flit[VALID_BIT]=1`:
  - If the FIFO is not full, or is popped in the same cycle, push `ej_flit` and increment `ej_count`.
  - Otherwise drop the flit and set `ej_overflow`.
- Flits with the valid bit at 0 are ignored.
- The router cannot be back-pressured, so overflow is reported, not prevented.
- `ej_overflow` clears only on reset.
- FIFO is first-word-fall-through: `core_rx_flit` = head whenever `core_rx_valid=1`.
- Pop when `core_rx_valid & core_rx_ready`.

**Simultaneous events**
- Injection push and pop in the same cycle: both take effect; occupancy is unchanged.
- Ejection push into a full FIFO with a same-cycle pop: the push is accepted and there is no overflow.
- `core_rx_ready` while empty: no effect.

**Reset** (asserted at any time, including mid-handshake)
- Both FIFOs empty, state IDLE.
- `inject_req=0`, `inj_flit=0`, `core_rx_valid=0`, `core_rx_flit=0`.
- `ej_overflow=0`, `inj_count=0`, `ej_count=0`.
- `core_tx_ready=1`.
- A flit held in REQ during reset is discarded.

## Timing
- Core push at edge E0 into an empty FIFO in IDLE: ARM at E1, REQ at E2, so `inject_req` rises 2 cycles after the push edge.
- Grant during REQ cycle k (FIFO pop at edge k+1):
  - With more entries queued: `inject_req` low in cycle k+1 (ARM), high again in cycle k+2.
  - With no entries left: IDLE in cycle k+1.
- `inj_count` updates at the grant edge.
- Ejected flit valid at edge E0: `core_rx_valid=1` in the following cycle; `ej_count` updates at E0.
- All outputs are registered or decoded from registered state only; there is no combinational path from `inject_grant` or `ej_flit` to any output.

## Test plan
- Reset with `inject_req`, `core_rx_valid`, `ej_overflow` and both counts at 0 and `core_tx_ready=1`. Push one flit, grant continuously → `inject_req` high 2 cycles later; exactly one injection; `inj_count=1`; FSM returns to IDLE.
- Fill the injection FIFO with 4 flits (`core_tx_ready` falls after the 4th), grant always high → 4 injections in 8 cycles, in order; `inj_flit` valid bit=1 only in ARM and REQ; each ARM cycle has `inject_req=0`.
- REQ with `inject_grant` held low for 5 cycles → `inj_flit` stable; no pop. Pulse the grant during ARM → ignored, `inj_count` unchanged.
- Eject 5 valid flits on consecutive cycles with `core_rx_ready=0` → first 4 stored; `ej_overflow=1`; `ej_count=4`. Then drain → data matches in order.
- Full ejection FIFO with `core_rx_ready=1` and a valid ejected flit in the same cycle → accepted; no overflow; occupancy stays 4.
- Assert `reset` asynchronously while in REQ with 3 queued and 2 ejected flits → all outputs at reset values immediately; no injection after release until new pushes; counters wrap from 0xFFFF to 0.
